// File: rtl/cgra_stream_io.sv
// Serial I/O engine for the FU fabric: deserialises one operand per lane MSB first,
// waits for the fabric, then serialises the captured results back out MSB first.
module cgra_stream_io #(
  parameter int NUM_LANES      = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int FABRIC_LATENCY = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [NUM_LANES-1:0]            data_i,
  output logic [NUM_LANES*DATA_WIDTH-1:0] operands_o,
  output logic                            operands_valid_o,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] results_i,
  output logic [NUM_LANES-1:0]            data_o,
  output logic                            data_valid_o,
  output logic                            busy_o,
  output logic                            done_o
);
  // state | meaning
  // IDLE  | waiting for start_i; operands_o keeps the last operands
  // RECV  | shifting operand bits in from data_i
  // WAIT  | operands complete, fabric computing
  // SEND  | shifting result bits out on data_o

  localparam int W     = DATA_WIDTH;
  localparam int L     = FABRIC_LATENCY;
  localparam int MAXWL = (W > L) ? W : L;
  localparam int CW    = (MAXWL > 1) ? $clog2(MAXWL) : 1;

  localparam logic [CW-1:0] CNT_RECV = CW'(W - 2);
  localparam logic [CW-1:0] CNT_WAIT = CW'(L - 1);
  localparam logic [CW-1:0] CNT_SEND = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RECV, WAIT, SEND} state_e;

  state_e                             state_q;
  logic [CW-1:0]                      cnt_q;
  logic [NUM_LANES-1:0][W-1:0]        op_q;
  logic [NUM_LANES-1:0][W-1:0]        res_q;
  logic                               done_q;
  logic [NUM_LANES-1:0][W-1:0]        op_shift;
  logic [NUM_LANES-1:0][W-1:0]        res_shift;

  always_comb begin
    op_shift  = '0;
    res_shift = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      op_shift[k]  = {op_q[k][W-2:0], data_i[k]};
      res_shift[k] = {res_q[k][W-2:0], 1'b0};
    end
  end

  // abort leaves the operand register alone so the fabric inputs do not glitch
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q    <= op_shift;
            state_q <= RECV;
            cnt_q   <= CNT_RECV;
          end
        end
        RECV: begin
          op_q <= op_shift;
          if (cnt_q == '0) begin
            state_q <= WAIT;
            cnt_q   <= CNT_WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            res_q   <= results_i;
            state_q <= SEND;
            cnt_q   <= CNT_SEND;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        SEND: begin
          res_q <= res_shift;
          if (cnt_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    data_o = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      data_o[k] = (state_q == SEND) & res_q[k][W-1];
    end
  end

  assign operands_o       = op_q;
  assign operands_valid_o = (state_q == WAIT);
  assign data_valid_o     = (state_q == SEND);
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;

endmodule

// File: tb/tb_cgra_stream_io.sv
// Self-checking bench for cgra_stream_io: operand/result scoreboards checked cycle by cycle.
module tb_cgra_stream_io;
  localparam int NL = 4;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int NC = 2*W + L;  // cycles 0..2W+L-1, the last being the done cycle

  logic              clk_i    = 1'b0;
  logic              reset_ni = 1'b1;
  logic              start_i  = 1'b0;
  logic              abort_i  = 1'b0;
  logic [NL-1:0]     data_i   = '0;
  logic [NL*W-1:0]   results_i = '0;
  logic [NL*W-1:0]   operands_o;
  logic              operands_valid_o;
  logic [NL-1:0]     data_o;
  logic              data_valid_o;
  logic              busy_o;
  logic              done_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NL-1:0]   bit_q[$];
  logic [NL*W-1:0] op_q[$];

  always #5 clk_i = ~clk_i;

  cgra_stream_io #(
    .NUM_LANES(NL), .DATA_WIDTH(W), .FABRIC_LATENCY(L)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
    .data_i(data_i), .operands_o(operands_o), .operands_valid_o(operands_valid_o),
    .results_i(results_i), .data_o(data_o), .data_valid_o(data_valid_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // One full transfer starting with start_i at the next edge; returns in the done cycle.
  task automatic run_xfer(input logic [W-1:0] op_base, input logic [W-1:0] res_base,
                          input logic [W-1:0] res_step, input bit stray);
    logic [NL*W-1:0] ops, res, exp_op;
    logic [NL-1:0]   exp_bits;
    logic            exp_busy, exp_opv, exp_dv, exp_done;
    for (int k = 0; k < NL; k++) begin
      ops[k*W +: W] = op_base + W'(k);
      res[k*W +: W] = res_base + res_step * W'(k);
    end
    op_q.push_back(ops);
    for (int b = W-1; b >= 0; b--) begin
      for (int k = 0; k < NL; k++) exp_bits[k] = res[k*W + b];
      bit_q.push_back(exp_bits);
    end
    exp_op = '0;
    for (int c = 0; c < NC; c++) begin
      start_i = (c == 0) || (stray && (c % 2 == 1));
      for (int k = 0; k < NL; k++) begin
        if (c < W) data_i[k] = ops[k*W + W-1-c];
        else       data_i[k] = 1'($urandom);
      end
      results_i = (c == W+L-1) ? res : (NL*W)'({$urandom, $urandom});
      @(posedge clk_i); #1;
      exp_busy = (c < NC-1);
      exp_opv  = (c >= W-1) && (c <= W+L-2);
      exp_dv   = (c >= W+L-1) && (c <= 2*W+L-2);
      exp_done = (c == NC-1);
      n_tests++;
      if (busy_o !== exp_busy) begin
        n_fail++;
        $display("FAIL busy c=%0d: got %b expected %b", c, busy_o, exp_busy);
      end
      n_tests++;
      if (operands_valid_o !== exp_opv) begin
        n_fail++;
        $display("FAIL operands_valid c=%0d: got %b expected %b", c, operands_valid_o, exp_opv);
      end
      n_tests++;
      if (data_valid_o !== exp_dv) begin
        n_fail++;
        $display("FAIL data_valid c=%0d: got %b expected %b", c, data_valid_o, exp_dv);
      end
      n_tests++;
      if (done_o !== exp_done) begin
        n_fail++;
        $display("FAIL done c=%0d: got %b expected %b", c, done_o, exp_done);
      end
      n_tests++;
      if (exp_dv) begin
        if (bit_q.size() == 0) begin
          n_fail++;
          $display("FAIL data_o c=%0d: got %h expected scoreboard entry, queue empty", c, data_o);
        end else begin
          exp_bits = bit_q.pop_front();
          if (data_o !== exp_bits) begin
            n_fail++;
            $display("FAIL data_o c=%0d: got %h expected %h", c, data_o, exp_bits);
          end
        end
      end else if (data_o !== '0) begin
        n_fail++;
        $display("FAIL data_o idle c=%0d: got %h expected 0", c, data_o);
      end
      if (c == W-1) begin
        exp_op = op_q.pop_front();
        n_tests++;
        if (operands_o !== exp_op) begin
          n_fail++;
          $display("FAIL operands c=%0d: got %h expected %h", c, operands_o, exp_op);
        end
      end
      if (c == NC-1) begin
        n_tests++;
        if (operands_o !== exp_op) begin
          n_fail++;
          $display("FAIL operands hold c=%0d: got %h expected %h", c, operands_o, exp_op);
        end
      end
    end
    start_i   = 1'b0;
    results_i = '0;
  endtask

  task automatic idle_cycles(input int n);
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    reset_ni = 1'b1;
    #2 reset_ni = 1'b0;
    #1;
    n_tests++;
    if ({operands_o, operands_valid_o, data_o, data_valid_o, busy_o, done_o} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h expected 0",
               {operands_o, operands_valid_o, data_o, data_valid_o, busy_o, done_o});
    end
    start_i = 1'b1;
    data_i  = '1;
    repeat (2) @(posedge clk_i);
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || operands_o !== '0) begin
      n_fail++;
      $display("FAIL reset held: got busy=%b operands=%h expected 0/0", busy_o, operands_o);
    end
    start_i = 1'b0;
    @(negedge clk_i) reset_ni = 1'b1;
    @(posedge clk_i); #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset release busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_operands_and_send;
    run_xfer(8'hA5, 8'h3C, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_xfer(8'h12, 8'h81, 8'h11, 1'b0);
    run_xfer(8'hC3, 8'h5E, 8'h27, 1'b0);
  endtask

  task automatic test_start_ignored;
    run_xfer(8'h6B, 8'hD2, 8'h0B, 1'b1);
  endtask

  task automatic test_abort;
    logic [NL*W-1:0] ops;
    logic            seen;
    for (int k = 0; k < NL; k++) ops[k*W +: W] = 8'h5A + W'(k);
    for (int c = 0; c <= 10; c++) begin
      start_i = (c == 0) || (c == 10);
      abort_i = (c == 10);
      for (int k = 0; k < NL; k++) data_i[k] = (c < W) ? ops[k*W + W-1-c] : 1'b0;
      results_i = '1;
      @(posedge clk_i); #1;
      if (c == 9) begin
        n_tests++;
        if (operands_valid_o !== 1'b1) begin
          n_fail++;
          $display("FAIL abort pre-wait: got operands_valid=%b expected 1", operands_valid_o);
        end
      end
    end
    n_tests++;
    if ({busy_o, operands_valid_o, data_valid_o, done_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort idle: got busy/opv/dv/done=%b expected 0000",
               {busy_o, operands_valid_o, data_valid_o, done_o});
    end
    n_tests++;
    if (operands_o !== ops) begin
      n_fail++;
      $display("FAIL abort operands kept: got %h expected %h", operands_o, ops);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      seen = seen | data_valid_o | done_o | busy_o | (|data_o);
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort quiet: got activity=%b expected 0", seen);
    end
    run_xfer(8'h0F, 8'hF0, 8'h01, 1'b0);
  endtask

  task automatic test_reset_mid_send;
    start_i   = 1'b1;
    data_i    = '1;
    results_i = '1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (W+L+2) @(posedge clk_i);
    #1;
    n_tests++;
    if (data_valid_o !== 1'b1 || data_o !== '1) begin
      n_fail++;
      $display("FAIL pre-reset send: got dv=%b data=%h expected 1/f", data_valid_o, data_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    n_tests++;
    if ({operands_o, operands_valid_o, data_o, data_valid_o, busy_o, done_o} !== '0) begin
      n_fail++;
      $display("FAIL async reset outputs: got %h expected 0",
               {operands_o, operands_valid_o, data_o, data_valid_o, busy_o, done_o});
    end
    @(negedge clk_i) reset_ni = 1'b1;
    @(posedge clk_i); #1;
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || data_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post-reset idle: got busy=%b done=%b dv=%b expected 0/0/0",
               busy_o, done_o, data_valid_o);
    end
    results_i = '0;
  endtask

  initial begin
    test_reset();
    idle_cycles(2);
    test_operands_and_send();
    idle_cycles(3);
    test_back_to_back();
    idle_cycles(2);
    test_start_ignored();
    idle_cycles(2);
    test_abort();
    idle_cycles(2);
    test_reset_mid_send();
    idle_cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
